// File: rtl/ctrl_decode_pipe.sv
// RV32I control decoder with ID/EX control register and mul/div occupancy FSM.
// Define RV32M_EN to decode M-extension ops and build the multi-cycle stall FSM.
module ctrl_decode_pipe #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        flush_e,
  output logic [2:0]  immsrc_d,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        jalr_e,
  output logic        alusrc_e,
  output logic [2:0]  resultsrc_e,
  output logic [4:0]  alucontrol_e,
  output logic [2:0]  funct3_e,
  output logic        valid_e,
  output logic        illegal_e,
  output logic        muldiv_busy
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010,
                         ALU_OR = 5'b00011, ALU_XOR = 5'b00100, ALU_SLT = 5'b00101,
                         ALU_SLL = 5'b00110, ALU_SRL = 5'b00111, ALU_SRA = 5'b01000,
                         ALU_SLTU = 5'b01001;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alusrc;
    logic [2:0] resultsrc;
    logic [4:0] alucontrol;
    logic [2:0] funct3;
    logic       valid;
    logic       illegal;
  } ectrl_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] alu_rr;
  logic       bad;
  ectrl_t     dec, e_q;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];

  logic unused_ok;
  assign unused_ok = ^{instr_d[24:15], instr_d[11:7]};

  always_comb begin
    case (funct3)
      3'b000:  alu_rr = (opcode == OP_R && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_rr = ALU_SLL;
      3'b010:  alu_rr = ALU_SLT;
      3'b011:  alu_rr = ALU_SLTU;
      3'b100:  alu_rr = ALU_XOR;
      3'b101:  alu_rr = instr_d[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_rr = ALU_OR;
      default: alu_rr = ALU_AND;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.funct3 = funct3;
    immsrc_d   = 3'b000;
    bad        = 1'b0;
    case (opcode)
      OP_R: begin
        dec.regwrite   = 1'b1;
        dec.alucontrol = alu_rr;
`ifdef RV32M_EN
        if (funct7 == 7'b0000001) dec.alucontrol = {2'b10, funct3};
        else
`endif
        if (funct7 == F7_ALT) bad = (funct3 != 3'b000) && (funct3 != 3'b101);
        else if (funct7 != F7_BASE) bad = 1'b1;
      end
      OP_I: begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = alu_rr;
        if (funct3 == 3'b001) bad = (funct7 != F7_BASE);
        else if (funct3 == 3'b101) bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OP_LD: begin
        dec.regwrite  = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 3'b001;
      end
      OP_ST: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        immsrc_d     = 3'b001;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        immsrc_d   = 3'b010;
        case (funct3[2:1])
          2'b00:   dec.alucontrol = ALU_SUB;
          2'b10:   dec.alucontrol = ALU_SLT;
          2'b11:   dec.alucontrol = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultsrc = 3'b010;
        immsrc_d      = 3'b011;
      end
      OP_JALR: begin
        dec.regwrite  = 1'b1;
        dec.jalr      = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 3'b010;
        bad           = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 3'b011;
        immsrc_d      = 3'b100;
      end
      OP_AUIPC: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 3'b100;
        immsrc_d      = 3'b100;
      end
      default: bad = 1'b1;
    endcase
    // Illegal ops keep funct3 for debug but must never write, branch or start the FSM.
    if (bad) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
      dec.funct3  = funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               e_q <= '0;
    else if (flush_e)      e_q <= '0;
    else if (!muldiv_busy) e_q <= valid_d ? dec : '0;
  end

`ifdef RV32M_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state;
  logic [3:0] cnt, n_last;
  logic       muldiv_e;

  assign muldiv_e = e_q.valid & e_q.alucontrol[4];
  assign n_last   = e_q.funct3[2] ? 4'(DIV_CYCLES - 1) : 4'(MUL_CYCLES - 1);
  // Busy covers the first E cycle too, so occupancy is exactly N cycles.
  assign muldiv_busy = (state == IDLE) ? (muldiv_e && n_last != 4'd0) : (cnt != n_last);

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (muldiv_e && n_last != 4'd0) begin
          state <= BUSY;
          cnt   <= 4'd1;
        end
        default: if (cnt == n_last) begin
          state <= IDLE;
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{MUL_CYCLES[0], DIV_CYCLES[0]};
  assign muldiv_busy = 1'b0;
`endif

  assign regwrite_e   = e_q.regwrite;
  assign memwrite_e   = e_q.memwrite;
  assign branch_e     = e_q.branch;
  assign jump_e       = e_q.jump;
  assign jalr_e       = e_q.jalr;
  assign alusrc_e     = e_q.alusrc;
  assign resultsrc_e  = e_q.resultsrc;
  assign alucontrol_e = e_q.alucontrol;
  assign funct3_e     = e_q.funct3;
  assign valid_e      = e_q.valid;
  assign illegal_e    = e_q.illegal;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe; M-extension checks run when RV32M_EN is defined.
module tb_ctrl_decode_pipe;
  logic        clk = 1'b0;
  logic        rst, valid_d, flush_e;
  logic [31:0] instr_d;
  logic [2:0]  immsrc_d, resultsrc_e, funct3_e;
  logic        regwrite_e, memwrite_e, branch_e, jump_e, jalr_e, alusrc_e;
  logic [4:0]  alucontrol_e;
  logic        valid_e, illegal_e, muldiv_busy;
  int          checks = 0;
  int          errors = 0;

  ctrl_decode_pipe #(.MUL_CYCLES(1), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .flush_e(flush_e),
    .immsrc_d(immsrc_d), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .alusrc_e(alusrc_e),
    .resultsrc_e(resultsrc_e), .alucontrol_e(alucontrol_e), .funct3_e(funct3_e),
    .valid_e(valid_e), .illegal_e(illegal_e), .muldiv_busy(muldiv_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins);
    instr_d = ins;
    valid_d = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_d = 1'b1; flush_e = 1'b0; instr_d = 32'h00000013;
    step(); step();
    chk("rst_valid", valid_e, 0);
    chk("rst_regwrite", regwrite_e, 0);
    chk("rst_alusrc", alusrc_e, 0);
    chk("rst_illegal", illegal_e, 0);
    chk("rst_busy", muldiv_busy, 0);
    rst = 1'b0;

    load(32'h00000013);
    chk("addi_valid", valid_e, 1);
    chk("addi_regwrite", regwrite_e, 1);
    chk("addi_alusrc", alusrc_e, 1);
    chk("addi_alu", alucontrol_e, 5'b00000);
    chk("addi_illegal", illegal_e, 0);

    load(32'h40B50533);
    chk("sub_alu", alucontrol_e, 5'b00001);
    chk("sub_alusrc", alusrc_e, 0);
    load(32'h40B55533);
    chk("sra_alu", alucontrol_e, 5'b01000);
    load(32'h40B56533);
    chk("alt_or_illegal", illegal_e, 1);
    chk("alt_or_regwrite", regwrite_e, 0);
    chk("alt_or_valid", valid_e, 1);

    instr_d = 32'h00000037; #1;
    chk("lui_immsrc", immsrc_d, 3'b100);
    load(32'h00000037);
    chk("lui_result", resultsrc_e, 3'b011);
    chk("lui_regwrite", regwrite_e, 1);
    load(32'h00000067);
    chk("jalr_jalr", jalr_e, 1);
    chk("jalr_result", resultsrc_e, 3'b010);
    chk("jalr_alusrc", alusrc_e, 1);
    load(32'h0000007F);
    chk("badop_illegal", illegal_e, 1);
    chk("badop_regwrite", regwrite_e, 0);

    instr_d = 32'h00B54063; #1;
    chk("blt_immsrc", immsrc_d, 3'b010);
    load(32'h00B54063);
    chk("blt_branch", branch_e, 1);
    chk("blt_alu", alucontrol_e, 5'b00101);
    chk("blt_funct3", funct3_e, 3'b100);
    chk("blt_regwrite", regwrite_e, 0);
    load(32'h00B52063);
    chk("br010_illegal", illegal_e, 1);
    chk("br010_branch", branch_e, 0);

    instr_d = 32'h00B52023; #1;
    chk("sw_immsrc", immsrc_d, 3'b001);
    load(32'h00B52023);
    chk("sw_memwrite", memwrite_e, 1);
    chk("sw_regwrite", regwrite_e, 0);
    load(32'h00052503);
    chk("lw_result", resultsrc_e, 3'b001);
    chk("lw_regwrite", regwrite_e, 1);
    instr_d = 32'h0000006F; #1;
    chk("jal_immsrc", immsrc_d, 3'b011);
    load(32'h0000006F);
    chk("jal_jump", jump_e, 1);
    chk("jal_result", resultsrc_e, 3'b010);
    load(32'h00000017);
    chk("auipc_result", resultsrc_e, 3'b100);
    load(32'h40155513);
    chk("srai_alu", alucontrol_e, 5'b01000);
    chk("srai_illegal", illegal_e, 0);
    load(32'h40151513);
    chk("slli_alt_illegal", illegal_e, 1);
    load(32'h00001067);
    chk("jalr_f3_illegal", illegal_e, 1);
    chk("jalr_f3_jalr", jalr_e, 0);

    valid_d = 1'b0; instr_d = 32'h00000013;
    step();
    chk("bubble_valid", valid_e, 0);
    chk("bubble_regwrite", regwrite_e, 0);
    flush_e = 1'b1;
    load(32'h00000013);
    flush_e = 1'b0;
    chk("flush_valid", valid_e, 0);

`ifdef RV32M_EN
    begin
      int nbusy;
      load(32'h02B54533);
      chk("div_alu", alucontrol_e, 5'b10100);
      instr_d = 32'h00000013;
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
        if (!muldiv_busy) break;
        nbusy++;
        chk("div_hold", alucontrol_e, 5'b10100);
        step();
      end
      chk("div_busy_cycles", nbusy, 7);
      chk("div_last_cycle", alucontrol_e, 5'b10100);
      step();
      chk("div_next_alu", alucontrol_e, 5'b00000);
      chk("div_next_regwrite", regwrite_e, 1);
      chk("div_next_busy", muldiv_busy, 0);

      load(32'h02B50533);
      chk("mul_alu", alucontrol_e, 5'b10000);
      chk("mul_busy", muldiv_busy, 0);
      load(32'h00000013);
      chk("mul_next_alu", alucontrol_e, 5'b00000);
      chk("mul_next_busy", muldiv_busy, 0);

      load(32'h02B54533);
      instr_d = 32'h00000013;
      step(); step();
      chk("flushdiv_busy_before", muldiv_busy, 1);
      flush_e = 1'b1;
      step();
      flush_e = 1'b0;
      chk("flushdiv_valid", valid_e, 0);
      chk("flushdiv_busy", muldiv_busy, 0);
      step();
      chk("flushdiv_idle_load", regwrite_e, 1);
      chk("flushdiv_idle_busy", muldiv_busy, 0);

      load(32'h02B54533);
      instr_d = 32'h00000013;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstdiv_valid", valid_e, 0);
      chk("rstdiv_busy", muldiv_busy, 0);
      load(32'h02B54533);
      chk("rstdiv_restart_busy", muldiv_busy, 1);
    end
`else
    load(32'h02B50533);
    chk("mul_off_illegal", illegal_e, 1);
    chk("mul_off_regwrite", regwrite_e, 0);
    chk("mul_off_busy", muldiv_busy, 0);
    load(32'h02B54533);
    chk("div_off_illegal", illegal_e, 1);
    chk("div_off_busy", muldiv_busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Full RV32I control decoder with an integrated ID/EX control pipeline register.
- Decodes the 32-bit instruction in the D stage into D-stage and E-stage controls. Emits a complete ALU control code instead of a 2-bit aluop, plus an illegal-instruction flag.
- Runs a cycle-count FSM that holds multi-cycle M-extension ops in E and requests a pipeline stall from the hazard unit.

Parameters:
- MUL_CYCLES, 2, E-stage occupancy in cycles for MUL/MULH/MULHSU/MULHU. Legal range 1..15.
- DIV_CYCLES, 8, E-stage occupancy in cycles for DIV/DIVU/REM/REMU. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_d  in  32  D-stage instruction
- valid_d  in  1  instr_d holds a real instruction
- flush_e  in  1  bubble the E-stage register (from hazard unit)
- immsrc_d  out  3  immediate format, combinational: I=000, S=001, B=010, J=011, U=100
- regwrite_e  out  1  registered
- memwrite_e  out  1  registered
- branch_e  out  1  registered
- jump_e  out  1  registered; JAL
- jalr_e  out  1  registered
- alusrc_e  out  1  registered; 1 = immediate operand
- resultsrc_e  out  3  registered: 000 ALU, 001 mem, 010 PC+4, 011 imm (LUI), 100 PC+imm (AUIPC)
- alucontrol_e  out  5  registered ALU code
- funct3_e  out  3  registered; branch condition and load/store width
- valid_e  out  1  registered
- illegal_e  out  1  registered
- muldiv_busy  out  1  combinational stall request to the hazard unit

Behaviour:
- Reset: all E-stage outputs are 0. FSM goes to IDLE and the counter to 0. muldiv_busy is 0.

Opcode decode:
- R 0110011: regwrite, resultsrc=000.
- I-ALU 0010011: regwrite, alusrc, immsrc=I.
- Load 0000011: regwrite, alusrc, resultsrc=001, alucontrol=ADD.
- Store 0100011: memwrite, alusrc, immsrc=S, alucontrol=ADD.
- Branch 1100011: branch, immsrc=B.
- JAL 1101111: regwrite, jump, immsrc=J, resultsrc=010.
- JALR 1100111: regwrite, jalr, alusrc, immsrc=I, resultsrc=010, alucontrol=ADD.
- LUI 0110111: regwrite, immsrc=U, resultsrc=011.
- AUIPC 0010111: regwrite, immsrc=U, resultsrc=100.

ALU codes and funct3 mapping:
- Codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLL 00110, SRL 00111, SRA 01000, SLTU 01001. M ops use {2'b10, funct3}.
- R/I funct3: 000 ADD, or SUB when R-type and funct7=0100000. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, or SRA when instr[30]=1. 110 OR, 111 AND.
- Branch funct3: 000/001 SUB, 100/101 SLT, 110/111 SLTU. funct3 010/011 is illegal.

Illegal-instruction rules:
- An instruction is illegal if any of these hold:
  - unknown opcode
  - R-type funct7 not in {0000000, 0100000}
  - funct7=0100000 with funct3 not in {000, 101}
  - I-type shift with instr[31:25] not 0000000, or not 0100000 for SRAI
  - JALR funct3 not equal to 000
- An illegal instruction loads as valid_e=1, illegal_e=1, all write/branch/jump controls 0.
- Don't-care encodings are forbidden: every output is a defined 0/1 for every input, including illegal ones.

E-register update, in priority order:
1. rst → zeros.
2. flush_e → bubble: all outputs 0, and FSM forced to IDLE with counter 0.
3. muldiv_busy → hold all E outputs.
4. Otherwise load decode. If valid_d=0, load a bubble.

Mul/div FSM:
- States: IDLE, BUSY.
- muldiv_e = valid_e & alucontrol_e[4]. N = MUL_CYCLES if funct3_e[2]=0, else DIV_CYCLES.
- IDLE: if muldiv_e and N>1, assert muldiv_busy combinationally, set counter=1, go to BUSY.
- BUSY: increment counter each cycle. muldiv_busy = (counter != N-1). When counter = N-1, deassert and go to IDLE while the E register loads the next instruction in that same edge.
- N=1 never asserts busy.
- Flush or reset in BUSY returns to IDLE immediately.

Optional Feature:
- Macro: RV32M_EN.
- Defined: R-type funct7=0000001 decodes as M ops (regwrite, resultsrc=000) and the FSM exists.
- Undefined: funct7=0000001 is illegal, no FSM is built, and muldiv_busy is tied to 0.

Test Plan:
- Reset, then instr 0x00000013 (addi x0,x0,0) with valid_d=1 → next cycle valid_e=1, regwrite_e=1, alusrc_e=1, alucontrol_e=00000, illegal_e=0.
- 0x40B50533 (sub) → alucontrol_e=00001. 0x40B55533 (sra) → 01000. 0x40B56533 (funct7=0100000, funct3=110) → illegal_e=1, regwrite_e=0.
- Opcode sweep: 0x00000037 → resultsrc_e=011, immsrc_d=100. 0x00000067 → jalr_e=1, resultsrc_e=010. Opcode 1111111 → illegal_e=1.
- RV32M_EN, DIV_CYCLES=8: 0x02B54533 (div) → muldiv_busy high exactly 7 cycles, E held, next instruction loads on the 8th edge. MUL with MUL_CYCLES=1 → busy never asserted.
- flush_e pulsed during BUSY cycle 3 → E bubbled, busy 0 next cycle, FSM IDLE. rst mid-BUSY → same.
- RV32M_EN undefined: 0x02B50533 → illegal_e=1, muldiv_busy stays 0.
